fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/avr_isa_pkg.sv | 23 ++
 rtl/avr_long_opcode.sv | 26 ++
 rtl/fetch_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/avr_isa_pkg.sv
// Shared AVR ISA definitions used by fetch and decode.
//
// Contents:
//   fetch_state_t   - fetch sequencer states (opcode word / operand word)
//   *_OP_HI/_OP_LO  - bit patterns that identify the two-word opcodes
//                     (LDS, STS, JMP, CALL); the high part is word[15:9].
//                     The LDS/STS low part is word[3:0]. The JMP/CALL low
//                     part is word[3:1].
package avr_isa_pkg;

    typedef enum logic {
        FETCH_FIRST  = 1'b0,
        FETCH_SECOND = 1'b1
    } fetch_state_t;

    localparam logic [6:0] LDS_OP_HI      = 7'b1001000;
    localparam logic [6:0] STS_OP_HI      = 7'b1001001;
    localparam logic [3:0] LDS_STS_OP_LO  = 4'b0000;
    localparam logic [6:0] JMP_CALL_OP_HI = 7'b1001010;
    localparam logic [2:0] JMP_OP_LO      = 3'b110;
    localparam logic [2:0] CALL_OP_LO     = 3'b111;

endpackage

// File: rtl/avr_long_opcode.sv
// Combinational detector for AVR opcodes that carry a second (operand) word.
//
// Ports:
//   word    - in,  16 bits: candidate opcode word
//   is_long - out, 1 bit  : high when word is LDS, STS, JMP or CALL
module avr_long_opcode (
    input  logic [15:0] word,
    output logic        is_long
);
    import avr_isa_pkg::*;

    // LDS/STS share an all-zero low nibble. JMP and CALL share a high pattern
    // and differ only in word[1]. The word[0] bit is part of the jump address.
    always_comb begin
        is_long = 1'b0;
        if (((word[15:9] == LDS_OP_HI) || (word[15:9] == STS_OP_HI)) &&
            (word[3:0] == LDS_STS_OP_LO)) begin
            is_long = 1'b1;
        end
        if ((word[15:9] == JMP_CALL_OP_HI) &&
            ((word[3:1] == JMP_OP_LO) || (word[3:1] == CALL_OP_LO))) begin
            is_long = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks the program ROM and assembles one- and
// two-word AVR instructions for decode, with a valid/ready handshake and
// redirect from downstream jumps/calls/returns.
//
// Ports:
//   clk            - in : clock, all state on posedge
//   rst_n          - in : synchronous active-low reset
//   rom_addr       - out: ROM word address (the PC register)
//   rom_data       - in : ROM word, registered by the ROM on negedge clk
//   redirect_valid - in : taken control transfer, highest priority
//   redirect_pc    - in : redirect target word address
//   instr_ready    - in : decode accepts the current instruction
//   instr_valid    - out: instr holds a complete instruction
//   instr          - out: {first word, second word}, second word 0 if short
//   instr_pc       - out: address of the first word
//   instr_long     - out: instruction is a two-word opcode
module fetch_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    input  logic [DATA_WIDTH-1:0]   rom_data,
    input  logic                    redirect_valid,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc,
    input  logic                    instr_ready,
    output logic                    instr_valid,
    output logic [2*DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]   instr_pc,
    output logic                    instr_long
);
    import avr_isa_pkg::*;

    fetch_state_t            state, state_next;
    logic [ADDR_WIDTH-1:0]   pc, pc_next;
    logic [ADDR_WIDTH-1:0]   instr_pc_next;
    logic [2*DATA_WIDTH-1:0] instr_next;
    logic                    instr_valid_next;
    logic                    instr_long_next;
    logic                    adv;
    logic                    word_is_long;

    avr_long_opcode u_long_opcode (
        .word    (rom_data[15:0]),
        .is_long (word_is_long)
    );

    assign rom_addr = pc;

    // A new word may be taken whenever the output slot is empty or decode is
    // taking what is there now. In SECOND instr_valid is always 0, so adv=1.
    assign adv = !instr_valid || instr_ready;

    // Next-state logic. Redirect beats everything and drops a half-built
    // two-word instruction. The first word of a long opcode is parked in the
    // upper half of instr while instr_valid stays low. Then the operand word
    // fills the lower half on the next edge.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instr_next       = instr;
        instr_pc_next    = instr_pc;
        instr_valid_next = instr_valid;
        instr_long_next  = instr_long;

        if (redirect_valid) begin
            pc_next          = redirect_pc;
            instr_valid_next = 1'b0;
            state_next       = FETCH_FIRST;
        end else begin
            case (state)
                FETCH_FIRST: begin
                    if (adv) begin
                        instr_next    = {rom_data, {DATA_WIDTH{1'b0}}};
                        instr_pc_next = pc;
                        pc_next       = pc + 1'b1;
                        if (word_is_long) begin
                            instr_valid_next = 1'b0;
                            instr_long_next  = 1'b1;
                            state_next       = FETCH_SECOND;
                        end else begin
                            instr_valid_next = 1'b1;
                            instr_long_next  = 1'b0;
                        end
                    end
                end
                FETCH_SECOND: begin
                    instr_next[DATA_WIDTH-1:0] = rom_data;
                    instr_valid_next           = 1'b1;
                    instr_long_next            = 1'b1;
                    pc_next                    = pc + 1'b1;
                    state_next                 = FETCH_FIRST;
                end
                default: begin
                    state_next       = FETCH_FIRST;
                    instr_valid_next = 1'b0;
                end
            endcase
        end
    end

    // State and output registers. Reset wins over redirect. Because pc is 0
    // during reset, the first edge after release sees the word at address 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH_FIRST;
            pc          <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            instr_long  <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr       <= instr_next;
            instr_pc    <= instr_pc_next;
            instr_valid <= instr_valid_next;
            instr_long  <= instr_long_next;
        end
    end

endmodule
